// File: rtl/data_mem_resp_if.sv
// Core-facing bus for the data memory responder: load/store ports, TX byte stream, status flags.
interface data_mem_resp_if;
  logic [63:0] RaddrIn;
  logic [63:0] WaddrIn;
  logic [63:0] WdataIn;
  logic [3:0]  Wmask;
  logic [63:0] RdataOut;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady;
  logic        MemErr;
  logic        TxOverflow;

  modport master (
    output RaddrIn, WaddrIn, WdataIn, Wmask, TxReady,
    input  RdataOut, TxData, TxValid, MemErr, TxOverflow
  );

  modport slave (
    input  RaddrIn, WaddrIn, WdataIn, Wmask, TxReady,
    output RdataOut, TxData, TxValid, MemErr, TxOverflow
  );
endinterface

// File: rtl/data_mem_resp.sv
// Data-side memory responder: byte-lane RAM, free-running mtime, and a TX byte FIFO
// behind a small MMIO map. Reads are combinational; stores commit on the clock edge.
module data_mem_resp #(
  parameter logic [63:0] RAM_BASE  = 64'h8000_0000,
  parameter int          RAM_DEPTH = 512,
  parameter int          TX_DEPTH  = 8
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_resp_if.slave bus
);
  localparam int          IW         = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int          PW         = $clog2(TX_DEPTH);
  localparam logic [63:0] RAM_END    = RAM_BASE + 64'(RAM_DEPTH) * 64'd8;
  localparam logic [63:0] MTIME_ADDR = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] TXD_ADDR   = 64'h0000_0000_1000_0000;
  localparam logic [63:0] TXS_ADDR   = 64'h0000_0000_1000_0008;

  logic [63:0]   ram [RAM_DEPTH];
  logic [7:0]    txMem [TX_DEPTH];
  logic [63:0]   mtime;
  logic [PW-1:0] wrPtr, rdPtr;
  logic [PW:0]   count;
  logic          memErr, txOvf;

  logic [63:0] rOff, wOff, wdataSh, rdata;
  logic [IW-1:0] rIdx, wIdx;
  logic          rInRam, wInRam;
  logic [7:0]    lanes, byteEn;
  logic          illegal, misaligned, storeErr, storeOk;
  logic          ramWe, push, pop, accept, full, empty;
  logic [3:0]    cnt4;

  assign rOff   = bus.RaddrIn - RAM_BASE;
  assign wOff   = bus.WaddrIn - RAM_BASE;
  assign rIdx   = rOff[IW+2:3];
  assign wIdx   = wOff[IW+2:3];
  assign rInRam = (bus.RaddrIn >= RAM_BASE) && (bus.RaddrIn < RAM_END);
  assign wInRam = (bus.WaddrIn >= RAM_BASE) && (bus.WaddrIn < RAM_END);

  // Size code -> unshifted lane mask; alignment checked against the access size.
  always_comb begin
    lanes      = 8'h00;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (bus.Wmask)
      4'h0: lanes = 8'h00;
      4'h1: lanes = 8'h01;
      4'h3: begin lanes = 8'h03; misaligned = bus.WaddrIn[0];       end
      4'hF: begin lanes = 8'h0F; misaligned = |bus.WaddrIn[1:0];    end
      4'h8: begin lanes = 8'hFF; misaligned = |bus.WaddrIn[2:0];    end
      default: illegal = 1'b1;
    endcase
  end

  assign storeErr = illegal | misaligned;
  assign storeOk  = (lanes != 8'h00) && !storeErr;
  assign byteEn   = lanes << bus.WaddrIn[2:0];
  assign wdataSh  = bus.WdataIn << {bus.WaddrIn[2:0], 3'b000};
  assign ramWe    = storeOk && wInRam;

  assign full   = (count == (PW+1)'(TX_DEPTH));
  assign empty  = (count == '0);
  assign push   = storeOk && (bus.WaddrIn == TXD_ADDR);
  assign pop    = !empty && bus.TxReady;
  assign accept = push && (!full || pop);
  assign cnt4   = 4'(count);

  // RAM has no reset; reads see the array before this edge's write.
  always_ff @(posedge clk) begin
    if (ramWe)
      for (int b = 0; b < 8; b++)
        if (byteEn[b]) ram[wIdx][8*b +: 8] <= wdataSh[8*b +: 8];
  end

  always_ff @(posedge clk) begin
    if (accept) txMem[wrPtr] <= bus.WdataIn[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime  <= '0;
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      memErr <= 1'b0;
      txOvf  <= 1'b0;
    end else begin
      mtime <= mtime + 64'd1;
      if (storeErr) memErr <= 1'b1;
      if (push && full && !pop) txOvf <= 1'b1;
      if (accept) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (rInRam)                         rdata = ram[rIdx];
    else if (bus.RaddrIn == MTIME_ADDR) rdata = mtime;
    else if (bus.RaddrIn == TXS_ADDR)   rdata = {56'b0, cnt4, 2'b00, full, empty};
  end

  assign bus.RdataOut   = rdata;
  assign bus.TxValid    = !empty;
  assign bus.TxData     = empty ? 8'h00 : txMem[rdPtr];
  assign bus.MemErr     = memErr;
  assign bus.TxOverflow = txOvf;
endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter RAM_BASE, default 64'h8000_0000: base byte address of the RAM region.
REQ-002 Parameter RAM_DEPTH, default 512: number of 64-bit RAM words (4 KiB).
REQ-003 Parameter TX_DEPTH, default 8: TX FIFO entries, a power of two and at least 2.
REQ-004 Clk  in  1  single clock; all state updates on rising edge.
REQ-005 Rst  in  1  asynchronous, active-high reset.
REQ-006 RaddrIn  in  64  load byte address from the core's memory stage.
REQ-007 WaddrIn  in  64  store byte address from the core's memory stage.
REQ-008 WdataIn  in  64  store data, right-aligned (byte 0 in bits [7:0]).
REQ-009 Wmask  in  4  store size code: 0x0 none, 0x1 byte, 0x3 half, 0xF word, 0x8 doubleword; any other code is treated as none and flagged as an error.
REQ-010 RdataOut  out  64  load data returned to the core: the raw aligned 64-bit word; the core performs extraction and sign extension.
REQ-011 TxData  out  8  head byte of the TX FIFO.
REQ-012 TxValid  out  1  TX FIFO is non-empty.
REQ-013 TxReady  in  1  sink accepts TxData on a cycle where TxValid=1 and TxReady=1.
REQ-014 MemErr  out  1  sticky error flag: misaligned store or illegal Wmask code.
REQ-015 TxOverflow  out  1  sticky flag: a byte was written while the FIFO was full.

Function
REQ-016 Address map (decoded on the full 64 bits):
- RAM: RAM_BASE to RAM_BASE+8*RAM_DEPTH-1.
- MTIME: 0x0200_BFF8.
- TX_DATA: 0x1000_0000 (write only).
- TX_STAT: 0x1000_0008 (read only).
- Any other address: unmapped.
REQ-017 Reads are combinational, with zero latency.
- RAM: RdataOut = RAM[(RaddrIn-RAM_BASE)>>3]; offset bits [2:0] are ignored.
- MTIME: RdataOut = mtime.
- TX_STAT: RdataOut = {56'b0, count[3:0], 2'b0, full, empty}.
- Unmapped: RdataOut = 0.
REQ-018 A read and a write to the same RAM word in the same cycle return the pre-write contents; the new data is visible from the next cycle.
REQ-019 A RAM store updates on the clock edge only the byte lanes selected by the size code, shifted left by WaddrIn[2:0].
REQ-020 Alignment rule: a store is misaligned when WaddrIn[2:0] is not a multiple of the access size (2/4/8 bytes).
- A misaligned or illegal-code store is suppressed (no write of any kind).
- MemErr is set on the following edge.
REQ-021 A store of any size to TX_DATA pushes WdataIn[7:0] when the FIFO is not full.
- When the FIFO is full, the byte is dropped and TxOverflow is set.
- Stores to MTIME, TX_STAT or unmapped addresses are ignored and do not raise errors.
REQ-022 The TX FIFO is a circular buffer with a write pointer, a read pointer and a count (0..TX_DEPTH); both pointers wrap modulo TX_DEPTH.
REQ-023 A pop occurs when TxValid=1 and TxReady=1.
- Push and pop in the same cycle: allowed when full or non-empty; count is unchanged and both pointers advance.
- Push and pop in the same cycle when full: the pop frees the slot, so the push is accepted and TxOverflow is not set.
- Push into an empty FIFO: TxValid rises on the next cycle; there is no fall-through in the same cycle.
REQ-024 mtime is a 64-bit free-running counter that increments by 1 every cycle and wraps from 2^64-1 to 0.
REQ-025 MemErr and TxOverflow clear only on reset.

Reset
REQ-026 While Rst=1, asynchronously:
- mtime=0; FIFO pointers and count=0.
- TxValid=0, TxData=0, MemErr=0, TxOverflow=0.
REQ-027 RAM contents are not reset; RdataOut during reset follows REQ-017.
REQ-028 Reset asserted mid-operation discards all FIFO contents with no drain; mtime restarts at 0 on the first edge after Rst falls.

Verification
REQ-029 SD 0x1122334455667788 @0x8000_0010, then SB 0xAA @0x8000_0013 -> read @0x8000_0010 returns 0x11223344AA667788.
REQ-030 SW @0x8000_0006 -> RAM unchanged, MemErr=1 from the next cycle; Wmask=0x5 -> write suppressed, MemErr=1.
REQ-031 With TxReady=0, push 9 bytes 0x01..0x09 -> TX_STAT=0x82 (count=8, full=1); TxOverflow=1; then TxReady=1 drains 0x01..0x08 in order on consecutive cycles, and TxValid=0 after the 8th.
REQ-032 FIFO full, push 0x55 while popping in the same cycle -> count stays 8, TxOverflow stays 0, and 0x55 emerges last.
REQ-033 Read MTIME 10 cycles after Rst falls -> value 10; assert Rst mid-count -> mtime reads 0 immediately.
REQ-034 Read and write to the same RAM word in the same cycle -> old data that cycle, new data the next cycle.
